// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl
// Sequences the NCO phase increment through stepped frequency sweeps
// (single ramp, repeating sawtooth, repeating triangle). It also marks the
// NCO output samples that belong to a settled step, using the NCO's fixed
// pipeline latency.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   cfg_start_inc       first phase increment (unsigned)
//   cfg_stop_inc        last phase increment (unsigned)
//   cfg_step            increment step magnitude (unsigned)
//   cfg_dwell           valid samples per step (0 behaves as 1)
//   cfg_mode            0 ramp, 1 sawtooth, 2 triangle, 3 as 0
//   start, abort        one-cycle control pulses
//   nco_out_valid       NCO output-valid strobe
//   nco_clken           NCO clock enable
//   nco_phi_inc         NCO phase increment
//   nco_freq_mod        NCO frequency modulation (always zero)
//   sample_valid        current NCO sample is settled and belongs to this step
//   step_first          first sample_valid of each step
//   busy                sweep in progress
//   done                one-cycle pulse when a ramp sweep completes
module nco_sweep_ctrl #(
    parameter int APR = 32,
    parameter int DWW = 16,
    parameter int LAT = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [APR-1:0] cfg_start_inc,
    input  logic [APR-1:0] cfg_stop_inc,
    input  logic [APR-1:0] cfg_step,
    input  logic [DWW-1:0] cfg_dwell,
    input  logic [1:0]     cfg_mode,
    input  logic           start,
    input  logic           abort,
    input  logic           nco_out_valid,
    output logic           nco_clken,
    output logic [APR-1:0] nco_phi_inc,
    output logic [APR-1:0] nco_freq_mod,
    output logic           sample_valid,
    output logic           step_first,
    output logic           busy,
    output logic           done
);
    localparam int SCW = (LAT < 1) ? 1 : $clog2(LAT + 1);
    localparam logic [SCW-1:0] SETTLE_LOAD = SCW'(LAT);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DWELL} state_t;

    state_t         state_reg, state_next;
    logic [APR-1:0] phi_reg, phi_next;
    logic [APR-1:0] start_sh_reg, start_sh_next;
    logic [APR-1:0] stop_sh_reg, stop_sh_next;
    logic [APR-1:0] step_sh_reg, step_sh_next;
    logic [DWW-1:0] dwell_sh_reg, dwell_sh_next;
    logic [1:0]     mode_sh_reg, mode_sh_next;
    logic           dir_up_reg, dir_up_next;
    logic           clken_reg, clken_next;
    logic           busy_reg, busy_next;
    logic           done_reg, done_next;
    logic [SCW-1:0] settle_cnt_reg, settle_cnt_next;
    logic [DWW-1:0] dwell_cnt_reg, dwell_cnt_next;

    logic           step_end;
    logic [APR-1:0] nxt_inc;
    logic           nxt_dir_up;
    logic           finish;

    // Add in APR+1 bits; a carry or reaching the limit clamps to the limit.
    function automatic logic [APR-1:0] step_up(input logic [APR-1:0] base,
                                               input logic [APR-1:0] step,
                                               input logic [APR-1:0] limit);
        logic [APR:0] sum;
        sum = {1'b0, base} + {1'b0, step};
        if (sum[APR] || (sum[APR-1:0] >= limit))
            return limit;
        return sum[APR-1:0];
    endfunction

    // Subtract in APR+1 bits; a borrow or reaching the floor clamps to the floor.
    function automatic logic [APR-1:0] step_down(input logic [APR-1:0] base,
                                                 input logic [APR-1:0] step,
                                                 input logic [APR-1:0] floor);
        logic [APR:0] diff;
        diff = {1'b0, base} - {1'b0, step};
        if (diff[APR] || (diff[APR-1:0] <= floor))
            return floor;
        return diff[APR-1:0];
    endfunction

    assign sample_valid = (state_reg == S_DWELL) && nco_out_valid;
    assign step_first   = sample_valid && (dwell_cnt_reg == '0);
    assign step_end     = sample_valid && (dwell_cnt_reg == dwell_sh_reg - DWW'(1));

    assign nco_clken    = clken_reg;
    assign nco_phi_inc  = phi_reg;
    assign nco_freq_mod = '0;
    assign busy         = busy_reg;
    assign done         = done_reg;

    // Increment to use after the current step, plus direction and completion.
    always_comb begin
        nxt_inc    = phi_reg;
        nxt_dir_up = dir_up_reg;
        finish     = 1'b0;
        if (dir_up_reg) begin
            // phi >= stop also covers stop <= start, where start is the only step
            if (phi_reg >= stop_sh_reg) begin
                case (mode_sh_reg)
                    2'd1: nxt_inc = start_sh_reg;
                    2'd2: begin
                        if (stop_sh_reg <= start_sh_reg) begin
                            nxt_inc = start_sh_reg;
                        end else begin
                            nxt_dir_up = 1'b0;
                            nxt_inc    = step_down(stop_sh_reg, step_sh_reg, start_sh_reg);
                        end
                    end
                    default: finish = 1'b1;
                endcase
            end else begin
                nxt_inc = step_up(phi_reg, step_sh_reg, stop_sh_reg);
            end
        end else begin
            if (phi_reg <= start_sh_reg) begin
                nxt_dir_up = 1'b1;
                nxt_inc    = step_up(start_sh_reg, step_sh_reg, stop_sh_reg);
            end else begin
                nxt_inc = step_down(phi_reg, step_sh_reg, start_sh_reg);
            end
        end
    end

    always_comb begin
        state_next      = state_reg;
        phi_next        = phi_reg;
        start_sh_next   = start_sh_reg;
        stop_sh_next    = stop_sh_reg;
        step_sh_next    = step_sh_reg;
        dwell_sh_next   = dwell_sh_reg;
        mode_sh_next    = mode_sh_reg;
        dir_up_next     = dir_up_reg;
        clken_next      = clken_reg;
        busy_next       = busy_reg;
        done_next       = 1'b0;
        settle_cnt_next = settle_cnt_reg;
        dwell_cnt_next  = dwell_cnt_reg;

        case (state_reg)
            S_IDLE: begin
                if (start && !abort) begin
                    start_sh_next   = cfg_start_inc;
                    stop_sh_next    = cfg_stop_inc;
                    step_sh_next    = cfg_step;
                    dwell_sh_next   = (cfg_dwell == '0) ? DWW'(1) : cfg_dwell;
                    mode_sh_next    = cfg_mode;
                    dir_up_next     = 1'b1;
                    phi_next        = cfg_start_inc;
                    clken_next      = 1'b1;
                    busy_next       = 1'b1;
                    settle_cnt_next = SETTLE_LOAD;
                    dwell_cnt_next  = '0;
                    state_next      = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    clken_next = 1'b0;
                    busy_next  = 1'b0;
                    state_next = S_IDLE;
                end else if (settle_cnt_reg <= SCW'(1)) begin
                    settle_cnt_next = '0;
                    state_next      = S_DWELL;
                end else begin
                    settle_cnt_next = settle_cnt_reg - SCW'(1);
                end
            end
            S_DWELL: begin
                if (abort) begin
                    clken_next = 1'b0;
                    busy_next  = 1'b0;
                    state_next = S_IDLE;
                end else if (step_end) begin
                    dwell_cnt_next = '0;
                    if (finish) begin
                        clken_next = 1'b0;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        phi_next        = nxt_inc;
                        dir_up_next     = nxt_dir_up;
                        settle_cnt_next = SETTLE_LOAD;
                        state_next      = S_SETTLE;
                    end
                end else if (sample_valid) begin
                    dwell_cnt_next = dwell_cnt_reg + DWW'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            phi_reg        <= '0;
            start_sh_reg   <= '0;
            stop_sh_reg    <= '0;
            step_sh_reg    <= '0;
            dwell_sh_reg   <= DWW'(1);
            mode_sh_reg    <= '0;
            dir_up_reg     <= 1'b1;
            clken_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            settle_cnt_reg <= '0;
            dwell_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            phi_reg        <= phi_next;
            start_sh_reg   <= start_sh_next;
            stop_sh_reg    <= stop_sh_next;
            step_sh_reg    <= step_sh_next;
            dwell_sh_reg   <= dwell_sh_next;
            mode_sh_reg    <= mode_sh_next;
            dir_up_reg     <= dir_up_next;
            clken_reg      <= clken_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            settle_cnt_reg <= settle_cnt_next;
            dwell_cnt_reg  <= dwell_cnt_next;
        end
    end
endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// Testbench for nco_sweep_ctrl. The expected increment sequence is built as
// lists (up ramp, down ramp) from the sweep rules; per-cycle timing follows
// "LAT masked cycles after each increment change, then dwell valid samples".
module tb_nco_sweep_ctrl;
    localparam int APR = 32;
    localparam int DWW = 16;
    localparam int LAT = 10;

    logic           clk = 1'b0;
    logic           reset;
    logic [APR-1:0] cfg_start_inc, cfg_stop_inc, cfg_step;
    logic [DWW-1:0] cfg_dwell;
    logic [1:0]     cfg_mode;
    logic           start, abort, nco_out_valid;
    logic           nco_clken, sample_valid, step_first, busy, done;
    logic [APR-1:0] nco_phi_inc, nco_freq_mod;

    int     vectors = 0;
    int     errors  = 0;
    longint exp_q[$];
    bit     exp_done;

    always #5 clk = ~clk;

    nco_sweep_ctrl #(.APR(APR), .DWW(DWW), .LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .cfg_start_inc(cfg_start_inc), .cfg_stop_inc(cfg_stop_inc),
        .cfg_step(cfg_step), .cfg_dwell(cfg_dwell), .cfg_mode(cfg_mode),
        .start(start), .abort(abort), .nco_out_valid(nco_out_valid),
        .nco_clken(nco_clken), .nco_phi_inc(nco_phi_inc),
        .nco_freq_mod(nco_freq_mod), .sample_valid(sample_valid),
        .step_first(step_first), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Expected increment per step: up ramp U, down ramp D, sequence
    // U, D, U[1:], D, ... for triangle; U repeated for sawtooth; U once for ramp.
    task automatic build_expected(input longint s, input longint e, input longint st,
                                  input int md, input int limit);
        longint up_q[$];
        longint dn_q[$];
        longint v;
        exp_q.delete();
        v = s;
        up_q.push_back(v);
        if (e > s) begin
            while (v < e && up_q.size() < limit) begin
                v = (v + st >= e) ? e : v + st;
                up_q.push_back(v);
            end
            v = e;
            while (v > s && dn_q.size() < limit) begin
                v = (v - st <= s) ? s : v - st;
                dn_q.push_back(v);
            end
        end
        exp_done = (md == 0 || md == 3) && (e <= s || up_q[up_q.size()-1] == e);
        foreach (up_q[i]) exp_q.push_back(up_q[i]);
        while (md == 1 && exp_q.size() < limit)
            foreach (up_q[i]) exp_q.push_back(up_q[i]);
        while (md == 2 && exp_q.size() < limit) begin
            if (up_q.size() == 1 || up_q[up_q.size()-1] != e) begin
                exp_q.push_back(up_q[up_q.size()-1]);
            end else begin
                foreach (dn_q[i]) exp_q.push_back(dn_q[i]);
                for (int i = 1; i < up_q.size(); i++) exp_q.push_back(up_q[i]);
            end
        end
    endtask

    // Runs one sweep. Ramp sweeps that complete are checked through done;
    // otherwise nsteps steps are checked and abort is pulsed at cycle
    // abort_cyc of the following step. vmode: 0 valid=1, 1 toggling, 2 random.
    task automatic run_case(input longint s, input longint e, input longint st,
                            input int dw, input int md, input int nsteps,
                            input int abort_cyc, input int vmode);
        int  dw_eff, total, cyc, valids, ov;
        bit  aborting, exp_sv, aborted;
        dw_eff = (dw == 0) ? 1 : dw;
        build_expected(s, e, st, md, 64);
        total = exp_done ? exp_q.size() : nsteps + 1;
        aborted = 0;
        cfg_start_inc = 32'(s); cfg_stop_inc = 32'(e); cfg_step = 32'(st);
        cfg_dwell = 16'(dw); cfg_mode = 2'(md);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < total && !aborted; k++) begin
            aborting = !exp_done && (k == nsteps);
            cyc = 0;
            valids = 0;
            forever begin
                // configuration and start are scrambled mid-sweep; both must be ignored
                cfg_start_inc = $urandom; cfg_stop_inc = $urandom; cfg_step = $urandom;
                cfg_dwell = 16'($urandom_range(0, 7)); cfg_mode = 2'($urandom_range(0, 3));
                start = !aborting && ($urandom_range(0, 7) == 0);
                case (vmode)
                    0: ov = 1;
                    1: ov = cyc % 2;
                    default: ov = (cyc > LAT + 4 * dw_eff) ? 1 : int'($urandom_range(0, 1));
                endcase
                if (aborting && valids == dw_eff - 1) ov = 0;
                abort = aborting && (cyc == abort_cyc);
                nco_out_valid = ov[0];
                @(negedge clk);
                exp_sv = (cyc >= LAT) && (ov != 0);
                chk("phi_inc", 64'(nco_phi_inc), exp_q[k]);
                chk("busy", 64'(busy), 1);
                chk("clken", 64'(nco_clken), 1);
                chk("sample_valid", 64'(sample_valid), 64'(exp_sv));
                chk("step_first", 64'(step_first), 64'(exp_sv && valids == 0));
                chk("done_low", 64'(done), 0);
                chk("freq_mod", 64'(nco_freq_mod), 0);
                if (exp_sv) valids++;
                @(posedge clk); #1;
                start = 1'b0;
                abort = 1'b0;
                if (aborting && cyc == abort_cyc) begin
                    aborted = 1;
                    break;
                end
                cyc++;
                if (valids == dw_eff) break;
                if (cyc > LAT + 8 * dw_eff + 20) begin
                    chk("step_budget_expired", 64'(cyc), 64'(LAT + 8 * dw_eff + 20));
                    reset = 1'b1;
                    @(posedge clk); #1;
                    reset = 1'b0;
                    return;
                end
            end
        end
        if (exp_done) begin
            nco_out_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("done_pulse", 64'(done), 1);
            chk("busy_end", 64'(busy), 0);
            chk("clken_end", 64'(nco_clken), 0);
            chk("phi_hold", 64'(nco_phi_inc), exp_q[exp_q.size()-1]);
            chk("sv_idle", 64'(sample_valid), 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("done_once", 64'(done), 0);
            @(posedge clk); #1;
        end else begin
            nco_out_valid = 1'b1;
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                chk("busy_abort", 64'(busy), 0);
                chk("clken_abort", 64'(nco_clken), 0);
                chk("sv_abort", 64'(sample_valid), 0);
                chk("done_abort", 64'(done), 0);
                @(posedge clk); #1;
            end
        end
        $display("case start=%0h stop=%0h step=%0h dwell=%0d mode=%0d steps=%0d %s",
                 s, e, st, dw, md, total, exp_done ? "completed" : "aborted");
    endtask

    initial begin
        longint s, e, st;
        int md;
        reset = 1'b1; start = 1'b0; abort = 1'b0; nco_out_valid = 1'b1;
        cfg_start_inc = '0; cfg_stop_inc = '0; cfg_step = '0; cfg_dwell = '0; cfg_mode = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_clken", 64'(nco_clken), 0);
        chk("rst_phi", 64'(nco_phi_inc), 0);
        chk("rst_sv", 64'(sample_valid), 0);
        chk("rst_first", 64'(step_first), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        $display("reset checked");

        run_case(64'h1000, 64'h1300, 64'h100, 4, 0, 0, 0, 0);
        run_case(64'h1000, 64'h1250, 64'h100, 4, 0, 0, 0, 2);
        run_case(64'h0, 64'h200, 64'h100, 1, 2, 8, 3, 2);
        run_case(64'h0, 64'h200, 64'h100, 2, 1, 6, 4, 0);
        run_case(64'h500, 64'h800, 64'h100, 3, 0, 0, 0, 1);
        run_case(64'hFFFFFF00, 64'hFFFFFFFF, 64'h200, 2, 0, 0, 0, 2);
        run_case(64'h3000, 64'h2000, 64'h100, 2, 0, 0, 0, 2);
        run_case(64'h3000, 64'h2000, 64'h100, 2, 2, 4, 11, 2);
        run_case(64'h4000, 64'h5000, 64'h0, 2, 0, 3, 12, 0);
        run_case(64'h100, 64'h400, 64'h180, 0, 3, 0, 0, 2);
        run_case(64'hFFFFFE00, 64'hFFFFFFFF, 64'h180, 1, 2, 9, 2, 2);

        // start and abort together: abort wins
        cfg_start_inc = 32'h1234; cfg_stop_inc = 32'h5678; cfg_step = 32'h10;
        cfg_dwell = 16'd2; cfg_mode = 2'd1;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("sa_busy", 64'(busy), 0);
            chk("sa_clken", 64'(nco_clken), 0);
            @(posedge clk); #1;
        end
        $display("start+abort checked");

        // reset during a sweep
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_busy", 64'(busy), 0);
        chk("mid_rst_clken", 64'(nco_clken), 0);
        chk("mid_rst_phi", 64'(nco_phi_inc), 0);
        chk("mid_rst_sv", 64'(sample_valid), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        $display("mid-sweep reset checked");

        for (int n = 0; n < 8; n++) begin
            s = longint'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                e = s >> 1;
            end else begin
                e = s + longint'($urandom_range(1, 32'h800));
                if (e > 64'hFFFFFFFF) e = 64'hFFFFFFFF;
            end
            st = (e > s) ? (e - s) / longint'($urandom_range(1, 5)) + 1 : longint'($urandom_range(1, 32'h100));
            md = $urandom_range(0, 3);
            run_case(s, e, st, $urandom_range(0, 5), md, $urandom_range(2, 9),
                     $urandom_range(0, LAT + 2), 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
- Sequences the NCO's phase-increment input to produce stepped frequency sweeps: single ramp, repeating sawtooth, or triangle.
- Drives the NCO clock enable and phase increment; frequency modulation input is tied to zero.
- Uses the NCO's fixed pipeline latency to mark which output samples belong to a settled frequency step.
- Sits between the host register bank and the NCO core in the TX chain.

Parameters:
APR, 32, phase accumulator / increment width
DWW, 16, dwell counter width (samples per step)
LAT, 10, NCO latency in cycles from a phase-increment change to the first output sample reflecting it

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cfg_start_inc  in  APR  first phase increment, unsigned
cfg_stop_inc  in  APR  last phase increment, unsigned
cfg_step  in  APR  increment step magnitude, unsigned
cfg_dwell  in  DWW  valid samples per step; 0 treated as 1
cfg_mode  in  2  0=single ramp, 1=sawtooth repeat, 2=triangle repeat, 3=reserved (behaves as 0)
start  in  1  one-cycle pulse; begins sweep
abort  in  1  one-cycle pulse; stops sweep
nco_out_valid  in  1  NCO out_valid
nco_clken  out  1  NCO clken
nco_phi_inc  out  APR  NCO phase increment
nco_freq_mod  out  APR  constant 0
sample_valid  out  1  NCO sample is settled and belongs to current step
step_first  out  1  pulse with first sample_valid of each step
busy  out  1  sweep in progress
done  out  1  one-cycle pulse at normal completion (mode 0/3 only)

Behaviour:
- Reset: state IDLE. All outputs 0: nco_clken, nco_phi_inc, sample_valid, step_first, busy, done. Direction = up. Counters cleared.
- States:
  - IDLE
  - SETTLE: settle counter running.
  - DWELL: counting sample_valid samples.
- IDLE + start:
  - Latch all cfg_* into shadow registers; cfg changes during a sweep are ignored.
  - Next cycle: nco_phi_inc=start_inc, nco_clken=1, busy=1, settle counter=LAT, state SETTLE.
- SETTLE: settle counter decrements every cycle. When it reaches 0, go to DWELL. sample_valid is 0 throughout.
- DWELL:
  - sample_valid = nco_out_valid.
  - Dwell counter increments on each sample_valid.
  - step_first is asserted with the first sample_valid of the step.
- End of step: the cycle holding the dwell-th sample_valid.
  - Compute the next increment in APR+1 bits.
  - Up direction: nxt = cur + step. If nxt >= stop, or on carry out, nxt = stop.
  - Down direction: nxt = cur - step. If nxt <= start, or on borrow, nxt = start.
  - nco_phi_inc updates the following cycle. Reload settle counter to LAT; state SETTLE.
- Terminal handling, up direction, cur == stop at end of step:
  - mode 0/3: next cycle nco_clken=0, busy=0, done=1 for one cycle, state IDLE. nco_phi_inc holds its last value.
  - mode 1: nxt = start.
  - mode 2: direction = down; nxt = stop - step, clamped as above.
- Terminal handling, down direction, cur == start (mode 2 only): direction = up; nxt = start + step, clamped.
- Degenerate configurations:
  - stop <= start: one step at start, then apply the terminal rule. Mode 1/2 repeat that single step indefinitely.
  - step == 0: sweep holds at start; mode 0 never completes; abort required.
- abort:
  - In SETTLE/DWELL: next cycle go to IDLE; nco_clken=0, busy=0, sample_valid=0; no done pulse.
  - abort in the same cycle as start from IDLE: abort wins; remain IDLE.
- start while busy: ignored.
- reset mid-sweep: immediate return to reset values on the next edge.
- nco_out_valid while in SETTLE or IDLE: never produces sample_valid.

Test Plan:
- Reset, then start with start=0x1000, stop=0x1300, step=0x100, dwell=4, mode 0, nco_out_valid tied 1 -> nco_phi_inc sequence 0x1000, 0x1100, 0x1200, 0x1300. Each step shows 10 masked cycles followed by 4 sample_valid. done pulses once; busy falls with it.
- Clamp: start=0x1000, stop=0x1250, step=0x100, mode 0 -> increments 0x1000, 0x1100, 0x1200, 0x1250, then done.
- Mode 2 with start=0, stop=0x200, step=0x100, dwell=1 -> 0, 0x100, 0x200, 0x100, 0, 0x100 ... Direction flips only at the endpoints; done never asserts.
- Mode 1, run two periods, then abort during SETTLE -> phi_inc wraps from 0x200 to 0. After abort, nco_clken=0 and busy=0 next cycle; no done pulse; sample_valid stays 0.
- nco_out_valid toggling 1/0 in DWELL with dwell=3 -> the step lasts 6 DWELL cycles; step_first coincides with the first valid sample only.
- Overflow: start=0xFFFFFF00, stop=0xFFFFFFFF, step=0x200 -> second step clamps to 0xFFFFFFFF with no wrap. Also: start+abort asserted in the same cycle -> stays IDLE.
